// File: rtl/riscv_ifetch_ctrl.sv
// Instruction-fetch controller: one IRAM read at a time, a single registered output
// slot with valid/ready to decode, and flush redirects that abort an in-flight access.
module riscv_ifetch_ctrl #(
  parameter int unsigned            ADDR_W    = 64,
  parameter logic [ADDR_W-1:0]      RESET_PC  = '0,
  parameter int unsigned            ABORT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              iram_rden,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [31:0]       iram_rdata,
  input  logic              mem_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              id_ready,
  output logic              fetch_busy
);

  localparam int unsigned CNT_W = (ABORT_CYC < 2) ? 1 : $clog2(ABORT_CYC + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_OUT, ABORT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              transfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      ipc_q   <= RESET_PC;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign transfer = valid_q & id_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // Flush wins over a same-cycle mem_ready or transfer; the IRAM counter may
      // still pulse after rden drops, so an active access must drain through ABORT.
      pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      valid_d = 1'b0;
      if (state_q == FETCH || state_q == ABORT) begin
        state_d = ABORT;
        cnt_d   = CNT_W'(ABORT_CYC);
      end else begin
        state_d = fetch_en ? FETCH : IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: if (fetch_en) state_d = FETCH;
        FETCH: if (mem_ready) begin
          instr_d = iram_rdata;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = WAIT_OUT;
        end
        WAIT_OUT: if (transfer) begin
          valid_d = 1'b0;
          state_d = fetch_en ? FETCH : IDLE;
        end
        ABORT: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = fetch_en ? FETCH : IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign iram_rden   = (state_q == FETCH);
  assign iram_addr   = pc_q;
  assign fetch_busy  = (state_q == FETCH) || (state_q == ABORT);
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_riscv_ifetch_ctrl.sv
// Directed bench for riscv_ifetch_ctrl with an IRAM access-counter model and a
// scoreboard queue of expected deliveries popped by an independent monitor.
module tb_riscv_ifetch_ctrl;
  localparam int unsigned ADDR_W = 64;
  localparam logic [63:0] RPC    = 64'h1000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_en, flush, id_ready;
  logic [ADDR_W-1:0] redirect_pc;
  logic              iram_rden, mem_ready, instr_valid, fetch_busy;
  logic [ADDR_W-1:0] iram_addr, instr_pc;
  logic [31:0]       iram_rdata, instr;

  typedef struct {logic [63:0] pc; logic [31:0] data;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  riscv_ifetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(RPC), .ABORT_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .flush(flush),
    .redirect_pc(redirect_pc), .iram_rden(iram_rden), .iram_addr(iram_addr),
    .iram_rdata(iram_rdata), .mem_ready(mem_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .id_ready(id_ready),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  // IRAM access counter: mem_ready in the 5th cycle of rden, keeps counting if rden drops
  logic [2:0]  mcnt = '0;
  logic [63:0] lat_addr = '0;
  always @(posedge clk) begin
    if (mcnt == 3'd4) mcnt <= '0;
    else if (iram_rden || mcnt != 3'd0) mcnt <= mcnt + 3'd1;
    if (iram_rden && mcnt == 3'd0) lat_addr <= iram_addr;
  end
  assign mem_ready  = (mcnt == 3'd4);
  assign iram_rdata = lat_addr[31:0] ^ 32'hDEAD_0013;

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc);
    exp_t e;
    e.pc = pc;
    e.data = data_of(pc);
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every real transfer
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (iram_rden && instr_valid) begin
        errors++;
        $display("FAIL rden_with_valid rden=%b valid=%b at %0t", iram_rden, instr_valid, $time);
      end
      if (instr_valid && id_ready && !flush) begin
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_delivery pc=%0h instr=%0h", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          if (instr_pc !== e.pc || instr !== e.data) begin
            errors++;
            $display("FAIL delivery got pc=%0h instr=%0h want pc=%0h instr=%0h",
                     instr_pc, instr, e.pc, e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; flush = 1'b0; id_ready = 1'b0; redirect_pc = '0;
    #22;
    chk("rst_rden", {63'd0, iram_rden}, 64'd0);
    chk("rst_addr", iram_addr, RPC);
    chk("rst_instr", {32'd0, instr}, 64'h13);
    chk("rst_ipc", instr_pc, RPC);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_busy", {63'd0, fetch_busy}, 64'd0);
    tick();
    rst_n = 1'b1;
    fetch_en = 1'b1;

    // first fetch: rden cycles 1-5, mem_ready at 5, valid at 6
    push(64'h1000);
    tick();
    for (int unsigned c = 1; c <= 4; c++) begin
      chk("t1_rden", {63'd0, iram_rden}, 64'd1);
      chk("t1_addr", iram_addr, 64'h1000);
      chk("t1_mrdy_early", {63'd0, mem_ready}, 64'd0);
      tick();
    end
    chk("t1_mrdy5", {63'd0, mem_ready}, 64'd1);
    chk("t1_valid5", {63'd0, instr_valid}, 64'd0);
    tick();
    chk("t1_valid6", {63'd0, instr_valid}, 64'd1);
    chk("t1_ipc", instr_pc, 64'h1000);

    // decode stall: output held, no new read
    for (int unsigned c = 0; c < 10; c++) begin
      tick();
      chk("t3_hold_valid", {63'd0, instr_valid}, 64'd1);
      chk("t3_hold_ipc", instr_pc, 64'h1000);
      chk("t3_hold_instr", {32'd0, instr}, {32'd0, data_of(64'h1000)});
      chk("t3_rden", {63'd0, iram_rden}, 64'd0);
    end
    id_ready = 1'b1;
    push(64'h1004);
    push(64'h1008);
    tick();
    chk("t3_valid_clr", {63'd0, instr_valid}, 64'd0);
    chk("t3_rden_next", {63'd0, iram_rden}, 64'd1);
    chk("t3_addr", iram_addr, 64'h1004);

    // steady stream, 6 cycles apart
    repeat (5) tick();
    chk("t2_valid_a", {63'd0, instr_valid}, 64'd1);
    chk("t2_ipc_a", instr_pc, 64'h1004);
    repeat (6) tick();
    chk("t2_valid_b", {63'd0, instr_valid}, 64'd1);
    chk("t2_ipc_b", instr_pc, 64'h1008);

    // flush at counter=2 of the 0x100C access
    tick();
    chk("t4_addr_old", iram_addr, 64'h100C);
    tick();
    tick();
    flush = 1'b1; redirect_pc = 64'h2003;
    tick();
    flush = 1'b0;
    chk("t4_ab1_rden", {63'd0, iram_rden}, 64'd0);
    chk("t4_ab1_busy", {63'd0, fetch_busy}, 64'd1);
    chk("t4_ab1_addr", iram_addr, 64'h2000);
    tick();
    chk("t4_ab2_rden", {63'd0, iram_rden}, 64'd0);
    chk("t4_stale_mrdy", {63'd0, mem_ready}, 64'd1);
    push(64'h2000);
    tick();
    chk("t4_rden", {63'd0, iram_rden}, 64'd1);
    chk("t4_addr", iram_addr, 64'h2000);
    chk("t4_valid_none", {63'd0, instr_valid}, 64'd0);
    repeat (5) tick();
    chk("t4_valid", {63'd0, instr_valid}, 64'd1);
    chk("t4_ipc", instr_pc, 64'h2000);

    // flush coincident with mem_ready on the 0x2004 access
    tick();
    repeat (4) tick();
    chk("t5_mrdy", {63'd0, mem_ready}, 64'd1);
    flush = 1'b1; redirect_pc = 64'h3000;
    tick();
    flush = 1'b0;
    chk("t5a_valid", {63'd0, instr_valid}, 64'd0);
    chk("t5a_rden", {63'd0, iram_rden}, 64'd0);
    tick();
    tick();
    chk("t5a_addr", iram_addr, 64'h3000);
    chk("t5a_rden2", {63'd0, iram_rden}, 64'd1);
    repeat (5) tick();
    chk("t5b_valid", {63'd0, instr_valid}, 64'd1);
    chk("t5b_ipc", instr_pc, 64'h3000);
    flush = 1'b1; redirect_pc = 64'h4000;
    tick();
    flush = 1'b0;
    chk("t5b_valid_clr", {63'd0, instr_valid}, 64'd0);
    chk("t5b_rden", {63'd0, iram_rden}, 64'd1);
    chk("t5b_addr", iram_addr, 64'h4000);
    push(64'h4000);
    repeat (5) tick();
    chk("t5b_ipc_new", instr_pc, 64'h4000);

    // redirect near the top of the address space, then wrap
    tick();
    tick();
    tick();
    flush = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    flush = 1'b0;
    tick();
    push(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("t6_addr_top", iram_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (5) tick();
    chk("t6_ipc_top", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("t6_wrap_addr", iram_addr, 64'd0);
    chk("t6_wrap_rden", {63'd0, iram_rden}, 64'd1);

    // asynchronous reset mid-access
    tick();
    #2;
    rst_n = 1'b0;
    fetch_en = 1'b0;
    #1;
    chk("t6_rst_rden", {63'd0, iram_rden}, 64'd0);
    chk("t6_rst_addr", iram_addr, RPC);
    chk("t6_rst_instr", {32'd0, instr}, 64'h13);
    chk("t6_rst_ipc", instr_pc, RPC);
    chk("t6_rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("t6_rst_busy", {63'd0, fetch_busy}, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 6; c++) begin
      tick();
      chk("t6_idle_rden", {63'd0, iram_rden}, 64'd0);
    end
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
